// File: rtl/acc_stack_pkg.sv
// acc_stack_pkg: shared definitions for the accumulator/save-stack block.
//   - operation code localparams (3-bit op field)
//   - helper functions sizing the select and stack index fields
package acc_stack_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_PUSH = 3'b010;
  localparam logic [2:0] OP_POP  = 3'b011;
  localparam logic [2:0] OP_SWAP = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;

  // Width of the source select field; never narrower than one bit.
  function automatic int sel_width(input int nsrc);
    if (nsrc <= 1) begin
      return 1;
    end else begin
      return $clog2(nsrc);
    end
  endfunction

  // Width of an index into a DEPTH-entry array; never narrower than one bit.
  function automatic int idx_width(input int depth);
    if (depth <= 1) begin
      return 1;
    end else begin
      return $clog2(depth);
    end
  endfunction

endpackage

// File: rtl/acc_lifo.sv
// acc_lifo: DEPTH x WIDTH LIFO storage with occupancy counter.
//   clk, rst   : clock, synchronous active-high reset (clears count and entries)
//   push       : write din at the next free slot, count+1
//   pop        : count-1 (entry contents are kept)
//   swap       : overwrite the top entry with din
//   din        : data written by push/swap
//   dout_top   : current top entry (0 when empty)
//   count      : occupied entries
//   full/empty : decodes of count
// The caller guarantees push is never raised when full and pop/swap never
// when empty; this module has no error handling of its own.
module acc_lifo
  import acc_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             swap,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout_top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int IW = idx_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_top_c;
  logic [IW-1:0]    w_top_idx;
  logic [IW-1:0]    w_nxt_idx;

  // count-1 wraps when empty, but the top index is only used when count > 0.
  assign w_top_c   = r_count - CW'(1);
  assign w_top_idx = w_top_c[IW-1:0];
  assign w_nxt_idx = r_count[IW-1:0];

  // Storage and counter update; one of push/pop/swap at most per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (push) begin
      r_mem[w_nxt_idx] <= din;
      r_count          <= r_count + CW'(1);
    end else if (pop) begin
      r_count <= w_top_c;
    end else if (swap) begin
      r_mem[w_top_idx] <= din;
    end else begin
      r_count <= r_count;
    end
  end

  assign dout_top = (r_count == '0) ? '0 : r_mem[w_top_idx];
  assign count    = r_count;
  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);

endmodule

// File: rtl/acc_stack_chk.sv
// acc_stack_chk: simulation-only invariants of the accumulator block.
//   R     : accumulator value, must never carry X/Z
//   count : stack occupancy, bounded by DEPTH
//   full/empty : never asserted together
module acc_stack_chk #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             rst,
  input logic [WIDTH-1:0] R,
  input logic [CW-1:0]    count,
  input logic             full,
  input logic             empty
);

  a_r_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(R))
    else $error("acc_stack_chk: R has X/Z bits");

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH))
    else $error("acc_stack_chk: count %0d exceeds depth", count);

  a_full_empty: assert property (@(posedge clk) disable iff (rst) !(full && empty))
    else $error("acc_stack_chk: full and empty both set");

endmodule

// File: rtl/acc_stack.sv
// acc_stack: accumulator register R with selectable load source and a
// LIFO save stack.
//   clk, rst : clock, synchronous active-high reset
//   iSrc     : NSRC sources packed, source k at [k*WIDTH +: WIDTH]
//   sel      : load source select (out-of-range selects load 0)
//   op       : HOLD/LOAD/PUSH/POP/SWAP/CLR, sampled each cycle
//   clr_err  : clears sticky error flags (a same-cycle new error wins)
//   R        : accumulator, signed
//   zero/neg : decodes of R
//   count/full/empty : stack occupancy
//   err_ovf  : sticky, push refused while full
//   err_udf  : sticky, pop/swap refused while empty
module acc_stack
  import acc_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NSRC  = 4,
  localparam int SW = sel_width(NSRC),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSRC*WIDTH-1:0]   iSrc,
  input  logic [SW-1:0]           sel,
  input  logic [2:0]              op,
  input  logic                    clr_err,
  output logic signed [WIDTH-1:0] R,
  output logic                    zero,
  output logic                    neg,
  output logic [CW-1:0]           count,
  output logic                    full,
  output logic                    empty,
  output logic                    err_ovf,
  output logic                    err_udf
);

  logic [WIDTH-1:0] r_acc;
  logic             r_err_ovf;
  logic             r_err_udf;

  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_top;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_do_swap;
  logic             w_set_ovf;
  logic             w_set_udf;

  // Source mux; a select beyond NSRC-1 matches no source and yields 0.
  always_comb begin
    w_src = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SW'(k)) begin
        w_src = iSrc[k*WIDTH +: WIDTH];
      end else begin
        w_src = w_src;
      end
    end
  end

  // Op decode with refusal gating: refused stack ops only raise an error.
  always_comb begin
    w_do_push = 1'b0;
    w_do_pop  = 1'b0;
    w_do_swap = 1'b0;
    w_set_ovf = 1'b0;
    w_set_udf = 1'b0;
    w_acc_nxt = r_acc;
    case (op)
      OP_LOAD: w_acc_nxt = w_src;
      OP_PUSH: begin
        w_do_push = !w_full;
        w_set_ovf = w_full;
      end
      OP_POP: begin
        w_do_pop  = !w_empty;
        w_set_udf = w_empty;
        if (!w_empty) begin
          w_acc_nxt = w_top;
        end else begin
          w_acc_nxt = r_acc;
        end
      end
      OP_SWAP: begin
        w_do_swap = !w_empty;
        w_set_udf = w_empty;
        if (!w_empty) begin
          w_acc_nxt = w_top;
        end else begin
          w_acc_nxt = r_acc;
        end
      end
      OP_CLR:  w_acc_nxt = '0;
      default: w_acc_nxt = r_acc;
    endcase
  end

  // Accumulator and sticky error flags; set takes priority over clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      r_acc     <= w_acc_nxt;
      r_err_ovf <= w_set_ovf | (r_err_ovf & ~clr_err);
      r_err_udf <= w_set_udf | (r_err_udf & ~clr_err);
    end
  end

  acc_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_do_push),
    .pop      (w_do_pop),
    .swap     (w_do_swap),
    .din      (r_acc),
    .dout_top (w_top),
    .count    (count),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign R       = r_acc;
  assign zero    = (r_acc == '0);
  assign neg     = r_acc[WIDTH-1];
  assign full    = w_full;
  assign empty   = w_empty;
  assign err_ovf = r_err_ovf;
  assign err_udf = r_err_udf;

`ifndef SYNTHESIS
  // Debug trace of accumulator changes.
  always @(r_acc) begin
    $display("acc_stack: R = 0x%0h", r_acc);
  end

  acc_stack_chk #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .R     (r_acc),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );
`endif

endmodule

// File: tb/tb_acc_stack.sv
module tb_acc_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int NSRC  = 3;

  logic        clk;
  logic        rst;
  logic [23:0] i_src;
  logic [1:0]  sel;
  logic [2:0]  op;
  logic        clr_err;
  logic [7:0]  r_o;
  logic        zero_o, neg_o, full_o, empty_o, ovf_o, udf_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: accumulator value, occupied stack entries, flags.
  logic [7:0] m_r;
  logic [7:0] m_q[$];
  logic       m_ovf;
  logic       m_udf;

  acc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NSRC(NSRC)) dut (
    .clk(clk), .rst(rst), .iSrc(i_src), .sel(sel), .op(op), .clr_err(clr_err),
    .R(r_o), .zero(zero_o), .neg(neg_o), .count(count_o), .full(full_o),
    .empty(empty_o), .err_ovf(ovf_o), .err_udf(udf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply the behavioural rules of one cycle to the model.
  task automatic model_step();
    logic new_ovf, new_udf;
    logic [7:0] t;
    new_ovf = 1'b0;
    new_udf = 1'b0;
    if (rst) begin
      m_r = 8'h00;
      m_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      case (op)
        3'd1: m_r = (int'(sel) < NSRC) ? i_src[sel*8 +: 8] : 8'h00;
        3'd2: if (m_q.size() == DEPTH) new_ovf = 1'b1; else m_q.push_back(m_r);
        3'd3: if (m_q.size() == 0) new_udf = 1'b1; else m_r = m_q.pop_back();
        3'd4: if (m_q.size() == 0) new_udf = 1'b1;
              else begin t = m_q[m_q.size()-1]; m_q[m_q.size()-1] = m_r; m_r = t; end
        3'd5: m_r = 8'h00;
        default: m_r = m_r;
      endcase
      m_ovf = new_ovf ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
      m_udf = new_udf ? 1'b1 : (clr_err ? 1'b0 : m_udf);
    end
  endtask

  // Drive one cycle, advance the model, compare every output after the edge.
  task automatic step(input logic [2:0] o, input logic [1:0] s, input logic c, input logic r);
    op = o; sel = s; clr_err = c; rst = r;
    @(posedge clk);
    model_step();
    #1;
    chk("R", r_o, m_r);
    chk("zero", zero_o, (m_r == 8'h00));
    chk("neg", neg_o, m_r[7]);
    chk("count", count_o, m_q.size());
    chk("full", full_o, (m_q.size() == DEPTH));
    chk("empty", empty_o, (m_q.size() == 0));
    chk("err_ovf", ovf_o, m_ovf);
    chk("err_udf", udf_o, m_udf);
  endtask

  task automatic load0(input logic [7:0] v);
    i_src[7:0] = v;
    step(3'd1, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    m_r = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    i_src = 24'h0; sel = 2'd0; op = 3'd0; clr_err = 1'b0; rst = 1'b1;
    #2;
    // Reset state
    step(3'd0, 2'd0, 1'b0, 1'b1);
    chk("rst_R", r_o, 8'h00);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_zero", zero_o, 1'b1);

    // LOAD from source 2
    i_src[23:16] = 8'h85;
    step(3'd1, 2'd2, 1'b0, 1'b0);
    chk("load_R", r_o, 8'h85);
    chk("load_neg", neg_o, 1'b1);

    // Fill the stack, then overflow
    load0(8'h11); step(3'd2, 2'd0, 1'b0, 1'b0);
    load0(8'h22); step(3'd2, 2'd0, 1'b0, 1'b0);
    load0(8'h33); step(3'd2, 2'd0, 1'b0, 1'b0);
    load0(8'h44); step(3'd2, 2'd0, 1'b0, 1'b0);
    chk("fill_full", full_o, 1'b1);
    step(3'd2, 2'd0, 1'b0, 1'b0);
    chk("ovf_flag", ovf_o, 1'b1);
    chk("ovf_count", count_o, 3'd4);
    chk("ovf_R", r_o, 8'h44);
    step(3'd3, 2'd0, 1'b0, 1'b0); chk("pop1", r_o, 8'h44);
    step(3'd3, 2'd0, 1'b0, 1'b0); chk("pop2", r_o, 8'h33);
    step(3'd3, 2'd0, 1'b0, 1'b0); chk("pop3", r_o, 8'h22);
    step(3'd3, 2'd0, 1'b0, 1'b0); chk("pop4", r_o, 8'h11);
    chk("pop_empty", empty_o, 1'b1);

    // Underflow on POP and SWAP, then clear
    step(3'd3, 2'd0, 1'b0, 1'b0);
    chk("udf_flag", udf_o, 1'b1);
    chk("udf_R", r_o, 8'h11);
    step(3'd4, 2'd0, 1'b0, 1'b0);
    chk("udf_swap_R", r_o, 8'h11);
    step(3'd0, 2'd0, 1'b1, 1'b0);
    chk("clr_udf", udf_o, 1'b0);

    // SWAP twice restores, then POP exposes original top
    load0(8'h05); step(3'd2, 2'd0, 1'b0, 1'b0);
    load0(8'h0A);
    step(3'd4, 2'd0, 1'b0, 1'b0); chk("swap1_R", r_o, 8'h05);
    step(3'd4, 2'd0, 1'b0, 1'b0); chk("swap2_R", r_o, 8'h0A);
    step(3'd3, 2'd0, 1'b0, 1'b0); chk("swap_pop", r_o, 8'h05);

    // Out-of-range select and CLR
    step(3'd1, 2'd3, 1'b0, 1'b0); chk("sel_oob", r_o, 8'h00);
    load0(8'h7F);
    step(3'd5, 2'd0, 1'b0, 1'b0); chk("clr_zero", zero_o, 1'b1);

    // Set both flags, then reset during a PUSH at count=2
    step(3'd3, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(3'd2, 2'd0, 1'b0, 1'b0);
    step(3'd3, 2'd0, 1'b0, 1'b0);
    step(3'd3, 2'd0, 1'b0, 1'b0);
    load0(8'h66);
    step(3'd2, 2'd0, 1'b0, 1'b1);
    chk("rst_mid_count", count_o, 3'd0);
    chk("rst_mid_ovf", ovf_o, 1'b0);
    chk("rst_mid_udf", udf_o, 1'b0);

    // clr_err with an overflowing PUSH: error wins
    for (int i = 0; i < 4; i++) step(3'd2, 2'd0, 1'b0, 1'b0);
    step(3'd2, 2'd0, 1'b1, 1'b0);
    chk("ovf_wins", ovf_o, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      i_src = 24'($urandom);
      step(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_stack.md
# acc_stack

Parametrised accumulator register for the CPU datapath with a selectable load source and a hardware LIFO save stack. It replaces the single fixed-width accumulator. The control unit can push R before a subroutine and pop it on return, swap R with the top-of-stack entry, or clear R. Overflow and underflow are reported through sticky error flags instead of corrupting state.

## Interface
Parameters:
- WIDTH, 8, data width of R, of each source and of each stack entry
- DEPTH, 4, number of stack entries (at least 1)
- NSRC, 4, number of load sources (at least 1)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- iSrc  in  NSRC*WIDTH  flattened source bus; source k occupies bits [k*WIDTH +: WIDTH]
- sel  in  max(1,clog2(NSRC))  load source select
- op  in  3  operation code, sampled every cycle
- clr_err  in  1  clears both sticky error flags
- R  out  WIDTH  accumulator value, signed
- zero  out  1  R == 0
- neg  out  1  R[WIDTH-1]
- count  out  clog2(DEPTH+1)  number of occupied stack entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- err_ovf  out  1  sticky flag: push attempted while full
- err_udf  out  1  sticky flag: pop or swap attempted while empty

## Operation
- Op encodings:
  - 000 HOLD
  - 001 LOAD: R <= iSrc[sel]; if sel >= NSRC, R <= 0
  - 010 PUSH: stack[count] <= R, count+1; R unchanged
  - 011 POP: R <= stack[count-1], count-1
  - 100 SWAP: R <= top of stack, top of stack <= old R; count unchanged
  - 101 CLR: R <= 0
  - 110 and 111: reserved, treated as HOLD
- Exactly one operation executes per cycle.
- PUSH while full: no state change except err_ovf <= 1.
- POP or SWAP while empty: no state change except err_udf <= 1.
- clr_err in the same cycle as a new error: the error wins, so the flag is set.
- Stack entry contents are not cleared on pop. Entries above count are don't-care internally and are never observable.
- R never carries X or Z bits. Unwritten stack entries are initialised to 0, so a later SWAP or POP cannot propagate X.
- Arithmetic: count is an unsigned counter that saturates by refusal; it never wraps. The stack is modified only at index count-1 (top) or count (next free).

## Timing
- Every op takes effect at the rising edge on which it is sampled. The new R, count and flags are visible the following cycle.
- Latency from op to R is 1 cycle for every op. The block has no stall and no busy signal.
- zero, neg, full and empty are combinational decodes of registered R and count, so they are glitch-free relative to clk.
- Back-to-back PUSH then POP returns the pushed value to R two edges after the PUSH.
- Reset values:
  - R = 0
  - count = 0
  - empty = 1, full = 0
  - zero = 1, neg = 0
  - err_ovf = 0, err_udf = 0
  - stack entries = 0
- rst overrides op and clr_err in the same cycle. A reset mid-sequence discards all stacked values.

## Structure
- Package acc_stack_pkg:
  - op encoding localparams (OP_HOLD, OP_LOAD, OP_PUSH, OP_POP, OP_SWAP, OP_CLR)
  - a function computing the sel width from NSRC
- Sub-module acc_lifo holds the DEPTH x WIDTH storage, count, and the full/empty decode.
  - Interface: push, pop, swap, din, dout_top, count.
  - acc_lifo performs no error logic.
- The top level holds R, the source mux, op decode, the error flags and the refusal gating.
- In simulation only, a debug $display fires on change of R. It is excluded under SYNTHESIS.
- The formal section asserts:
  - R has no X/Z bits
  - count <= DEPTH
  - full and empty are never both 1

## Test plan
- Reset, then LOAD sel=2 with iSrc[2]=0x85 -> R=0x85, neg=1, zero=0 one cycle later.
- With DEPTH=4: PUSH R=0x11, 0x22, 0x33, 0x44 (LOAD between) -> count=4, full=1. Fifth PUSH -> count stays 4, err_ovf=1, R unchanged. Then four POPs -> R=0x44, 0x33, 0x22, 0x11, and empty=1.
- From empty: POP -> err_udf=1, R unchanged. Next cycle SWAP -> still unchanged. clr_err -> err_udf=0.
- R=0x0A with top=0x05: SWAP -> R=0x05, top=0x0A, count unchanged. A second SWAP restores the originals.
- LOAD with sel=NSRC (out of range, needs NSRC not a power of 2, e.g. NSRC=3, sel=3) -> R=0. CLR from R=0x7F -> R=0, zero=1.
- Assert rst during a PUSH with count=2 -> next cycle R=0, count=0, both error flags 0. Assert clr_err together with an overflowing PUSH -> err_ovf=1.
